// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scanner: register map, CTRL bit
// positions and the active-low hex-to-segment table.
package sevenseg_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CTRL_W  = 9;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned PRESC_W = 24;
    localparam int unsigned BUS_W   = 32;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_DP_LSB  = 1;
    localparam int unsigned CTRL_LZB_BIT = 8;

    localparam logic [BUS_W-1:0] DATA_OFS = 32'h0000_0000;
    localparam logic [BUS_W-1:0] CTRL_OFS = 32'h0000_0004;

    localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h7F;
    localparam logic [DIGITS-1:0] AN_OFF    = 4'hF;

    // Entry n holds the pattern for hex digit n; seg[0]=a .. seg[6]=g, low = lit.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/sevenseg_scanner_hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg
    import sevenseg_pkg::*;
(
    input  logic [NIB_W-1:0] hex,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = HEX_SEG[hex];

endmodule

// File: rtl/sevenseg_scanner.sv
// Memory-mapped 4-digit multiplexed seven-segment driver with leading-zero
// blanking, per-digit decimal points and a ghost-suppression gap between digits.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int unsigned      REFRESH_DIV = 100000,
    parameter logic [BUS_W-1:0] BASE_ADDR   = 32'h0000_0800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [BUS_W-1:0]  dataadr,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    output logic [SEG_W-1:0]  seg,
    output logic [DIGITS-1:0] an,
    output logic              dp
);

    logic [DATA_W-1:0]  data_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [PRESC_W-1:0] presc_q;
    logic [IDX_W-1:0]   idx_q;
    logic               ghost_q;

    logic               sel_data_c;
    logic               sel_ctrl_c;
    logic               slot_end_c;
    logic [NIB_W-1:0]   nib_c;
    logic [SEG_W-1:0]   dec_c;
    logic               upper_zero_c;
    logic               show_c;
    logic               dp_bit_c;
    logic               unused_wd;

    assign unused_wd = ^writedata[BUS_W-1:DATA_W];

    assign sel_data_c = (dataadr == BASE_ADDR + DATA_OFS);
    assign sel_ctrl_c = (dataadr == BASE_ADDR + CTRL_OFS);
    assign slot_end_c = (presc_q == PRESC_W'(REFRESH_DIV - 1));

    // Readback is purely address-decoded and ignores the write strobe.
    always_comb begin
        readdata = '0;
        if (sel_data_c) begin
            readdata = BUS_W'(data_q);
        end else if (sel_ctrl_c) begin
            readdata = BUS_W'(ctrl_q);
        end
    end

    assign nib_c    = data_q[{idx_q, 2'b00} +: NIB_W];
    assign dp_bit_c = ctrl_q[4'(CTRL_DP_LSB) + 4'(idx_q)];

    hex7seg u_hex7seg (
        .hex   (nib_c),
        .seg_c (dec_c)
    );

    // Digit k is a leading zero when it and every more-significant nibble is zero.
    always_comb begin
        upper_zero_c = 1'b0;
        unique case (idx_q)
            2'd1:    upper_zero_c = (data_q[15:4]  == 12'h000);
            2'd2:    upper_zero_c = (data_q[15:8]  == 8'h00);
            2'd3:    upper_zero_c = (data_q[15:12] == 4'h0);
            default: upper_zero_c = 1'b0;
        endcase
    end

    assign show_c = ctrl_q[CTRL_EN_BIT] && !ghost_q
                    && !(ctrl_q[CTRL_LZB_BIT] && upper_zero_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            ctrl_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            ghost_q <= 1'b0;
            seg     <= SEG_BLANK;
            an      <= AN_OFF;
            dp      <= 1'b1;
        end else begin
            presc_q <= slot_end_c ? '0 : presc_q + PRESC_W'(1);
            if (slot_end_c) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            // Marks the first cycle after an index change so that cycle stays dark.
            ghost_q <= slot_end_c;

            if (memwrite && sel_data_c) begin
                data_q <= writedata[DATA_W-1:0];
            end
            if (memwrite && sel_ctrl_c) begin
                ctrl_q <= writedata[CTRL_W-1:0];
            end

            if (show_c) begin
                seg <= dec_c;
                an  <= ~(DIGITS'(1) << idx_q);
                dp  <= ~dp_bit_c;
            end else begin
                seg <= SEG_BLANK;
                an  <= AN_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Scoreboard bench for sevenseg_scanner with a cycle-count based reference model.
module tb_sevenseg_scanner;

    localparam int unsigned DIV  = 4;
    localparam logic [31:0] BASE = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0]  hexlut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0] m_data = '0;
    logic [8:0]  m_ctrl = '0;
    int          m_cnt  = 0;

    always #5 clk = ~clk;

    sevenseg_scanner #(
        .REFRESH_DIV (DIV),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .seg       (seg),
        .an        (an),
        .dp        (dp)
    );

    // Display seen after the next edge, from elapsed cycles since reset.
    function automatic exp_t predict();
        exp_t        e;
        int          k;
        bit          ghost;
        logic [15:0] upper;
        k     = (m_cnt / DIV) % 4;
        ghost = (m_cnt % DIV == 0) && (m_cnt > 0);
        upper = m_data >> (4 * k);
        e = '{seg: 7'h7F, an: 4'hF, dp: 1'b1};
        if (m_ctrl[0] && !ghost && !(m_ctrl[8] && k > 0 && upper == 16'h0)) begin
            e.seg = hexlut[upper[3:0]];
            e.an  = 4'(~(4'b0001 << k));
            e.dp  = ~m_ctrl[1 + k];
        end
        return e;
    endfunction

    always @(posedge clk) begin : model
        exp_t e;
        if (reset) begin
            e = '{seg: 7'h7F, an: 4'hF, dp: 1'b1};
            m_data = '0;
            m_ctrl = '0;
            m_cnt  = 0;
        end else begin
            e = predict();
            m_cnt++;
            if (memwrite && dataadr == BASE)
                m_data = writedata[15:0];
            else if (memwrite && dataadr == BASE + 32'd4)
                m_ctrl = writedata[8:0];
        end
        exp_q.push_back(e);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] rd;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an",  32'(an),  32'(e.an));
            check("seg", 32'(seg), 32'(e.seg));
            check("dp",  32'(dp),  32'(e.dp));
            rd = 32'h0;
            if (dataadr == BASE)               rd = {16'h0, m_data};
            else if (dataadr == BASE + 32'd4)  rd = {23'h0, m_ctrl};
            check("readdata", readdata, rd);
        end
    end

    task automatic step(input logic rst, input logic mw, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        reset     = rst;
        memwrite  = mw;
        dataadr   = a;
        writedata = wd;
    endtask

    task automatic idle(input int n, input logic [31:0] a);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, $urandom);
    endtask

    initial begin
        bit          found;
        logic [31:0] a;
        int          sel;
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = BASE;
        writedata = '0;
        repeat (3) @(posedge clk);
        idle(4, BASE);

        // Plain scan 4,3,2,1
        step(1'b0, 1'b1, BASE, 32'hFFFF_1234);
        step(1'b0, 1'b1, BASE + 32'd4, 32'h1);
        idle(40, BASE);

        // Leading-zero blanking
        step(1'b0, 1'b1, BASE, 32'h0000_0005);
        step(1'b0, 1'b1, BASE + 32'd4, 32'h101);
        idle(40, BASE + 32'd4);

        // Decimal point on digit 1 only
        step(1'b0, 1'b1, BASE, 32'h0000_8888);
        step(1'b0, 1'b1, BASE + 32'd4, 32'h005);
        idle(40, BASE);

        // Unmapped write is ignored
        step(1'b0, 1'b1, BASE + 32'd8, $urandom);
        idle(10, BASE + 32'd8);
        idle(4, BASE);
        idle(4, BASE + 32'd4);

        // Reset in the middle of digit 2's slot
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if ((m_cnt / DIV) % 4 == 2 && m_cnt % DIV == 1) found = 1'b1;
            else idle(1, BASE);
        end
        if (!found) begin
            errors++;
            $display("FAIL mid_digit2_wait: got timeout want digit 2 reached");
        end
        step(1'b1, 1'b1, BASE, 32'h0000_4321);
        step(1'b0, 1'b1, BASE + 32'd4, 32'h1);
        idle(30, BASE);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       a = BASE;
                1:       a = BASE + 32'd4;
                2:       a = BASE + 32'd8;
                default: a = $urandom;
            endcase
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), a, $urandom);
        end
        idle(4, BASE);
        @(negedge clk);
        @(negedge clk);

        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want <=1", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sevenseg_scanner.md
SEVENSEG_SCANNER -- requirements
Module: sevenseg_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (legal 2..2^24-1).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0800, word address of the DATA register; CTRL is at BASE_ADDR+4.
REQ-003 SHALL have clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have memwrite  input  1  bus write strobe from the processor.
REQ-006 SHALL have dataadr  input  32  bus byte address.
REQ-007 SHALL have writedata  input  32  bus write data.
REQ-008 SHALL have readdata  output  32  register readback.
REQ-009 SHALL have seg  output  7  segment cathodes, active-low, seg[0]=a .. seg[6]=g.
REQ-010 SHALL have an  output  4  digit anodes, active-low, an[0]=rightmost digit.
REQ-011 SHALL have dp  output  1  decimal point, active-low.

Function
REQ-012 SHALL write DATA[15:0] from writedata[15:0] when memwrite=1 and dataadr==BASE_ADDR, effective next edge.
REQ-013 SHALL write CTRL[8:0] from writedata[8:0] when memwrite=1 and dataadr==BASE_ADDR+4; bit0 EN, bits[4:1] DP mask per digit, bit8 LZB (leading-zero blank).
REQ-014 SHALL ignore writes to any other address; writedata[31:16] of DATA and [31:9] of CTRL ignored.
REQ-015 SHALL drive readdata combinationally: {16'h0,DATA} at BASE_ADDR, {23'h0,CTRL} at BASE_ADDR+4, 32'h0 otherwise, independent of memwrite.
REQ-016 SHALL run a prescaler counting 0..REFRESH_DIV-1 then wrapping to 0; digit index (2 bits) increments 3->0 wrap on the cycle prescaler is at REFRESH_DIV-1.
REQ-017 SHALL, for digit index k, select nibble DATA[4k+3:4k], decode hex 0-F to active-low segments, dp = ~CTRL[1+k].
REQ-018 SHALL register seg, an, dp; outputs reflect index, DATA and CTRL as of the previous edge (1-cycle latency).
REQ-019 SHALL drive an = ~(4'b0001 << k) when EN=1, an=4'hF, seg=7'h7F, dp=1 when EN=0.
REQ-020 SHALL, when LZB=1, blank (an bit high) digit k>0 if all nibbles k..3 are zero; digit 0 never blanked.
REQ-021 SHALL insert one ghost-suppression cycle: on the cycle following an index change only, an=4'hF.
REQ-022 SHALL continue scanning during EN=0 (prescaler and index not frozen).
REQ-023 SHALL give a write in the same cycle as a digit switch the new value on the next displayed cycle, no torn nibble.

Reset
REQ-024 SHALL on reset=1 at an edge clear DATA=0, CTRL=0, prescaler=0, index=0, set seg=7'h7F, an=4'hF, dp=1.
REQ-025 SHALL let reset take priority over a simultaneous memwrite; reset mid-scan restarts at digit 0 with full slot.

Structure
REQ-026 SHALL place the 16-entry hex-to-segment table, CTRL bit-position constants and register offsets in shared package sevenseg_pkg.
REQ-027 SHALL use one sub-module hex7seg (combinational 4-bit to 7-bit active-low decode); BASE_ADDR decoding stays in this module.

Verification (REFRESH_DIV=4)
REQ-028 SHALL check reset: after reset an=4'hF, seg=7'h7F, dp=1, readdata at BASE_ADDR = 0.
REQ-029 SHALL check write DATA=32'hFFFF_1234, CTRL=1 -> readback 32'h0000_1234; an cycles E,D,B,7 every 4 clks showing 4,3,2,1 (seg 7'h19,7'h30,7'h24,7'h79).
REQ-030 SHALL check LZB: DATA=16'h0005, CTRL=9'h101 -> only an[0] ever low, seg=7'h12; digits 1-3 blank.
REQ-031 SHALL check DP mask CTRL=9'h005 -> dp=0 only while an=4'hD (digit 1).
REQ-032 SHALL check write to BASE_ADDR+8 -> DATA/CTRL unchanged, readdata=0 at that address.
REQ-033 SHALL check ghost cycle: an=4'hF for exactly one clk after each index change; reset asserted mid-digit-2 -> next active digit is 0 after full 4-clk slot.
